seven_seg_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment display driver. It is the next generation of the fixed 4-digit scanner and drives NUM_DIGITS common-anode digits from a hex shadow buffer. Compared with the 4-digit scanner it adds a load-strobed display buffer, per-digit decimal points, leading-zero suppression, per-digit blink, PWM brightness and a frame-done pulse. It sits between datapath/counter logic and the board's 7-segment pins.

---
 rtl/seven_seg_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment driver: shadow buffer, leading-zero blanking,
// per-digit blink, PWM brightness and a frame-done pulse.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS        = 4,
  parameter int unsigned CLKS_PER_DIGIT    = 65536,
  parameter int unsigned BRIGHT_BITS       = 3,
  parameter int unsigned BLINK_FRAMES_LOG2 = 6,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_suppress,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned SlotW  = $clog2(CLKS_PER_DIGIT);
  localparam int unsigned SubLen = CLKS_PER_DIGIT >> BRIGHT_BITS;
  localparam int unsigned SubW   = (SubLen > 1) ? $clog2(SubLen) : 1;
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned FrameW = (BLINK_FRAMES_LOG2 > 0) ? BLINK_FRAMES_LOG2 : 1;

  localparam logic [SlotW-1:0]  SlotMax  = SlotW'(CLKS_PER_DIGIT - 1);
  localparam logic [SubW-1:0]   SubMax   = SubW'(SubLen - 1);
  localparam logic [IdxW-1:0]   IdxMax   = IdxW'(NUM_DIGITS - 1);
  localparam logic [FrameW-1:0] FrameMax = FrameW'((1 << BLINK_FRAMES_LOG2) - 1);
  localparam logic              Inv      = ACTIVE_LOW;

  logic [SlotW-1:0]        slot_cnt_q, slot_cnt_d;
  logic [SubW-1:0]         sub_cnt_q, sub_cnt_d;
  logic [BRIGHT_BITS-1:0]  sub_phase_q, sub_phase_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [FrameW-1:0]       frame_cnt_q, frame_cnt_d;
  logic                    blink_q, blink_d;
  logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [3:0]              cur_nib_q, cur_nib_d;
  logic                    cur_dp_q, cur_dp_d;
  logic                    cur_lz_q, cur_lz_d;
  logic [6:0]              seg_q;
  logic                    dp_q, frame_done_q;
  logic [NUM_DIGITS-1:0]   an_q;

  logic                  slot_wrap, sub_wrap, frame_end;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [6:0]            glyph, seg_on;
  logic                  dp_on, blank_lz, blank_blink;
  logic [NUM_DIGITS-1:0] an_on;

  // upper_zero[i]: every shadow digit at index i and above is zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (shadow_dig_q[4*NUM_DIGITS-1 -: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (shadow_dig_q[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    slot_wrap   = (slot_cnt_q == SlotMax);
    sub_wrap    = (sub_cnt_q == SubMax);
    frame_end   = slot_wrap && (idx_q == IdxMax);
    slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    sub_cnt_d   = (slot_wrap || sub_wrap) ? '0 : sub_cnt_q + 1'b1;
    sub_phase_d = slot_wrap ? '0 : (sub_wrap ? sub_phase_q + 1'b1 : sub_phase_q);
    idx_d       = frame_end ? '0 : (slot_wrap ? idx_q + 1'b1 : idx_q);
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (frame_end) begin
      frame_cnt_d = (frame_cnt_q == FrameMax) ? '0 : frame_cnt_q + 1'b1;
      if (frame_cnt_q == FrameMax) blink_d = ~blink_q;
    end
    shadow_dig_d = load ? digits_in : shadow_dig_q;
    shadow_dp_d  = load ? dp_in : shadow_dp_q;
    // Capture for the upcoming slot uses the pre-load shadow, so a coincident load
    // only becomes visible one slot later.
    cur_nib_d = cur_nib_q;
    cur_dp_d  = cur_dp_q;
    cur_lz_d  = cur_lz_q;
    if (slot_wrap) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (IdxW'(i) == idx_d) begin
          cur_nib_d = shadow_dig_q[4*i +: 4];
          cur_dp_d  = shadow_dp_q[i];
          cur_lz_d  = upper_zero[i];
        end
      end
    end
  end

  always_comb begin
    unique case (cur_nib_q)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = 7'h00;
    endcase
    blank_lz    = lz_suppress && cur_lz_q && (idx_q != '0);
    blank_blink = blink_q && blink_mask[idx_q];
    seg_on      = (blank_lz || blank_blink) ? 7'h00 : glyph;
    dp_on       = cur_dp_q && !blank_blink;
    an_on       = '0;
    if (sub_phase_q <= brightness) an_on[idx_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt_q   <= '0;
      sub_cnt_q    <= '0;
      sub_phase_q  <= '0;
      idx_q        <= '0;
      frame_cnt_q  <= '0;
      blink_q      <= 1'b0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      cur_nib_q    <= '0;
      cur_dp_q     <= 1'b0;
      cur_lz_q     <= 1'b0;
      seg_q        <= {7{Inv}};
      dp_q         <= Inv;
      an_q         <= {NUM_DIGITS{Inv}};
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      sub_cnt_q    <= sub_cnt_d;
      sub_phase_q  <= sub_phase_d;
      idx_q        <= idx_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_q      <= blink_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      cur_nib_q    <= cur_nib_d;
      cur_dp_q     <= cur_dp_d;
      cur_lz_q     <= cur_lz_d;
      seg_q        <= seg_on ^ {7{Inv}};
      dp_q         <= dp_on ^ Inv;
      an_q         <= an_on ^ {NUM_DIGITS{Inv}};
      frame_done_q <= frame_end;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized bench for seven_seg_scan_ctrl against a time-indexed reference model.
module tb_seven_seg_scan_ctrl;

  localparam int N   = 4;
  localparam int CPD = 16;
  localparam int BB  = 2;
  localparam int BL  = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4*N-1:0] digits_in = '0;
  logic [N-1:0]  dp_in = '0;
  logic          load = 1'b0;
  logic          lz_suppress = 1'b0;
  logic [N-1:0]  blink_mask = '0;
  logic [BB-1:0] brightness = '0;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  an;
  logic          frame_done;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS       (N),
    .CLKS_PER_DIGIT   (CPD),
    .BRIGHT_BITS      (BB),
    .BLINK_FRAMES_LOG2(BL),
    .ACTIVE_LOW       (1'b1)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .load       (load),
    .lz_suppress(lz_suppress),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Active-high glyphs {g,f,e,d,c,b,a} for 0-9, A, b, C, d, E, F.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: t counts cycles since reset release; snap is the buffer seen by the current slot.
  int         t;
  logic [3:0] sh_dig [N];
  logic [3:0] snap_dig [N];
  logic       sh_dp [N];
  logic       snap_dp [N];
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic [N-1:0] exp_an;
  logic       exp_fd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int j = 0; j < N; j++) begin
      sh_dig[j] = 4'h0; snap_dig[j] = 4'h0; sh_dp[j] = 1'b0; snap_dp[j] = 1'b0;
    end
  endtask

  task automatic model_step();
    int idx, pos, sub;
    logic blink, all_zero, blank_blink;
    logic [6:0] seg_hi;
    logic dp_hi;
    idx = (t / CPD) % N;
    pos = t % CPD;
    sub = pos / (CPD >> BB);
    blink = (((t / (CPD * N)) >> BL) % 2) == 1;
    all_zero = 1'b1;
    for (int j = idx; j < N; j++) if (snap_dig[j] != 4'h0) all_zero = 1'b0;
    blank_blink = blink && blink_mask[idx];
    seg_hi = glyph[snap_dig[idx]];
    if ((lz_suppress && idx != 0 && all_zero) || blank_blink) seg_hi = 7'h00;
    dp_hi = snap_dp[idx] && !blank_blink;
    exp_seg = ~seg_hi;
    exp_dp  = ~dp_hi;
    exp_an  = ~((sub <= int'(brightness)) ? N'(1 << idx) : N'(0));
    exp_fd  = (pos == CPD - 1) && (idx == N - 1);
    if (pos == CPD - 1) begin
      for (int j = 0; j < N; j++) begin snap_dig[j] = sh_dig[j]; snap_dp[j] = sh_dp[j]; end
    end
    if (load) begin
      for (int j = 0; j < N; j++) begin sh_dig[j] = digits_in[4*j +: 4]; sh_dp[j] = dp_in[j]; end
    end
    t++;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("seg", 32'(seg), 32'(exp_seg));
    check("dp", 32'(dp), 32'(exp_dp));
    check("an", 32'(an), 32'(exp_an));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    check("an_exclusive", 32'($countones(~an) <= 1), 32'd1);
  endtask

  // Called at a negedge; checks the asynchronous effect before any clock edge.
  task automatic apply_reset();
    reset = 1'b1;
    load  = 1'b0;
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drive(input int load_pct);
    logic [15:0] v;
    load = 1'b0;
    if ($urandom_range(99) < load_pct || ((t % CPD) == CPD - 1 && $urandom_range(3) == 0)) begin
      v = 16'($urandom);
      v = v >> $urandom_range(16);  // bias towards leading zeros
      load = 1'b1;
      digits_in = v;
      dp_in = N'($urandom);
    end
    if ($urandom_range(199) == 0) brightness = BB'($urandom);
    if ($urandom_range(299) == 0) lz_suppress = ~lz_suppress;
  endtask

  initial begin
    @(negedge clk);
    apply_reset();

    digits_in = 16'h1A3F;
    dp_in = 4'b0100;
    brightness = 2'd3;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (200) step();

    lz_suppress = 1'b1;
    digits_in = 16'h0050;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (140) step();
    digits_in = 16'h0000;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (140) step();

    for (int ph = 0; ph < 12; ph++) begin
      brightness = BB'($urandom);
      lz_suppress = 1'($urandom);
      blink_mask = N'($urandom);
      repeat (250) begin
        drive(5);
        step();
      end
    end

    load = 1'b0;
    for (int k = 0; k < 2 * CPD * N && !(((t / CPD) % N) == 2 && (t % CPD) == 5); k++) step();
    check("reset_mid_slot2", 32'((t / CPD) % N), 32'd2);
    apply_reset();
    blink_mask = '0;
    repeat (150) begin
      drive(3);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
